lut_1058_serial_rx: RTL and testbench

- Upstream feeder for lut_1058: deserialises a framed serial bit stream into a parallel WIDTH-bit word and drives it onto the LUT input b.
- Samples the LUT's combinational result s in the cycle the new word is presented; keeps a saturating count of LUT hits.
- Single clock domain; bit timing is set by an external bit-strobe, not by the clock.

---
 rtl/lut_1058_serial_rx_if.sv | 16 +
 rtl/lut_1058_serial_rx.sv | 100 ++++++++++
 tb/tb_lut_1058_serial_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lut_1058_serial_rx_if.sv
// lut_1058_serial_rx_if: serial-in / LUT-side bundle for the lut_1058 feeder.
interface lut_1058_serial_rx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             sen;
  logic             sdata;
  logic             s;
  logic [WIDTH-1:0] b;
  logic             b_valid;
  logic             frame_err;
  logic [CNT_W-1:0] hit_cnt;
  logic             busy;
  modport master (output sen, sdata, s, input b, b_valid, frame_err, hit_cnt, busy);
  modport slave  (input sen, sdata, s, output b, b_valid, frame_err, hit_cnt, busy);
endinterface

// File: rtl/lut_1058_serial_rx.sv
// lut_1058_serial_rx: strobed serial deserialiser feeding lut_1058 input b, with saturating hit count.
// Define PARITY_CHECK_EN to expect one even-parity bit between the data and stop bits.
module lut_1058_serial_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  lut_1058_serial_rx_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, r_b;
  logic [BW-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_hit;
  logic             r_b_valid, r_frame_err;
  logic             w_load, w_err, w_good, w_last;
`ifdef PARITY_CHECK_EN
  logic             r_par, w_par_nxt;
  assign w_good = bus.sdata & ~^{r_shift, r_par};
`else
  assign w_good = bus.sdata;
`endif
  assign w_last = r_cnt == BW'(WIDTH - 1);
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
`ifdef PARITY_CHECK_EN
    w_par_nxt   = r_par;
`endif
    w_load      = 1'b0;
    w_err       = 1'b0;
    if (bus.sen) begin
      case (r_state)
        IDLE: if (!bus.sdata) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
        end
        DATA: begin
          w_shift_nxt = {r_shift[WIDTH-2:0], bus.sdata};
          w_cnt_nxt   = r_cnt + BW'(1);
`ifdef PARITY_CHECK_EN
          w_state_nxt = w_last ? PARITY : DATA;
`else
          w_state_nxt = w_last ? STOP : DATA;
`endif
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          w_par_nxt   = bus.sdata;
          w_state_nxt = STOP;
        end
`endif
        STOP: begin
          w_state_nxt = IDLE;
          w_load      = w_good;
          w_err       = !w_good;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
`ifdef PARITY_CHECK_EN
      r_par       <= 1'b0;
`endif
      r_b         <= '0;
      r_b_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_hit       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
`ifdef PARITY_CHECK_EN
      r_par       <= w_par_nxt;
`endif
      r_b         <= w_load ? r_shift : r_b;
      r_b_valid   <= w_load;
      r_frame_err <= w_err;
      // s answers for the freshly presented b, so it is only meaningful while b_valid is high
      r_hit       <= (r_b_valid && bus.s && !(&r_hit)) ? r_hit + CNT_W'(1) : r_hit;
    end
  end
  assign bus.b         = r_b;
  assign bus.b_valid   = r_b_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.hit_cnt   = r_hit;
  assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_lut_1058_serial_rx.sv
// tb_lut_1058_serial_rx: randomized frames checked against a frame-level model of the deserialiser.
module tb_lut_1058_serial_rx;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lut_1058_serial_rx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  lut_1058_serial_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [15:0] mask = '0;
  assign bus.s = mask[bus.b];
  int checks = 0;
  int failures = 0;
  int nv, ne;
  logic [3:0] exp_b;
  int exp_hit;
  logic exp_good;
  task automatic step(input logic en, input logic d);
    bus.sen = en;
    bus.sdata = d;
    @(posedge clk);
    #1;
    nv += int'(bus.b_valid);
    ne += int'(bus.frame_err);
  endtask
  task automatic send_bit(input logic d, input int gap);
    repeat (gap) step(1'b0, 1'($urandom));
    step(1'b1, d);
  endtask
  task automatic send_frame(input logic [3:0] w, input logic stop, input logic par, input int gap);
    nv = 0;
    ne = 0;
    send_bit(1'b0, gap);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], gap);
`ifdef PARITY_CHECK_EN
    send_bit(par, gap);
`endif
    send_bit(stop, gap);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask
  task automatic model(input logic [3:0] w, input logic stop, input logic par);
`ifdef PARITY_CHECK_EN
    exp_good = stop && ((^w) == par);
`else
    exp_good = stop;
`endif
    if (exp_good) begin
      exp_b = w;
      if (mask[w] && exp_hit < 255) exp_hit++;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    rst_n = 1'b1;
    exp_b = '0;
    exp_hit = 0;
  endtask
  task automatic test_reset();
    do_reset();
    checks += 5;
    if (bus.b !== 4'h0) begin failures++; $display("FAIL reset_b got=%h want=0", bus.b); end
    if (bus.b_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b want=0", bus.b_valid); end
    if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b want=0", bus.frame_err); end
    if (bus.hit_cnt !== 8'h00) begin failures++; $display("FAIL reset_hit_cnt got=%h want=00", bus.hit_cnt); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
  endtask
  task automatic test_basic();
    mask = '0;
    send_frame(4'hA, 1'b1, ^4'hA, 0);
    model(4'hA, 1'b1, ^4'hA);
    checks += 4;
    if (bus.b !== exp_b) begin failures++; $display("FAIL basic_b got=%h want=%h", bus.b, exp_b); end
    if (nv !== 1) begin failures++; $display("FAIL basic_valid_pulses got=%0d want=1", nv); end
    if (ne !== 0) begin failures++; $display("FAIL basic_err_pulses got=%0d want=0", ne); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b want=0", bus.busy); end
  endtask
  task automatic test_bad_stop();
    send_frame(4'hC, 1'b0, ^4'hC, 0);
    model(4'hC, 1'b0, ^4'hC);
    checks += 3;
    if (ne !== 1) begin failures++; $display("FAIL badstop_err_pulses got=%0d want=1", ne); end
    if (nv !== 0) begin failures++; $display("FAIL badstop_valid_pulses got=%0d want=0", nv); end
    if (bus.b !== 4'hA) begin failures++; $display("FAIL badstop_b got=%h want=a", bus.b); end
  endtask
  task automatic test_sweep();
    int order[16];
    int tv;
    do_reset();
    mask = '0;
    while ($countones(mask) < 4) mask[$urandom_range(15)] = 1'b1;
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    tv = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] w;
      w = 4'(order[i]);
      send_frame(w, 1'b1, ^w, 3);
      model(w, 1'b1, ^w);
      tv += nv;
      checks++;
      if (bus.b !== exp_b) begin failures++; $display("FAIL sweep_b got=%h want=%h", bus.b, exp_b); end
    end
    checks += 2;
    if (tv !== 16) begin failures++; $display("FAIL sweep_valid_total got=%0d want=16", tv); end
    if (int'(bus.hit_cnt) !== 4 || exp_hit !== 4) begin failures++; $display("FAIL sweep_hit_cnt got=%0d want=4", bus.hit_cnt); end
  endtask
  task automatic test_mid_reset();
    mask = '1;
    send_frame(4'hF, 1'b1, ^4'hF, 0);
    model(4'hF, 1'b1, ^4'hF);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    rst_n = 1'b0;
    nv = 0;
    ne = 0;
    step(1'b0, 1'b1);
    exp_b = '0;
    exp_hit = 0;
    checks += 4;
    if (bus.b !== 4'h0 || nv !== 0 || ne !== 0) begin failures++; $display("FAIL midrst_outs b=%h valid=%0d err=%0d want 0", bus.b, nv, ne); end
    if (bus.hit_cnt !== 8'h00) begin failures++; $display("FAIL midrst_hit got=%h want=00", bus.hit_cnt); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    rst_n = 1'b1;
    mask = '0;
    send_frame(4'h3, 1'b1, ^4'h3, 0);
    model(4'h3, 1'b1, ^4'h3);
    if (bus.b !== 4'h3 || nv !== 1 || ne !== 0) begin failures++; $display("FAIL midrst_frame b=%h valid=%0d err=%0d want b=3 valid=1 err=0", bus.b, nv, ne); end
  endtask
  task automatic test_saturation();
    do_reset();
    mask = '1;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] w;
      w = 4'($urandom);
      send_frame(w, 1'b1, ^w, 0);
      model(w, 1'b1, ^w);
      checks++;
      if (int'(bus.hit_cnt) !== exp_hit) begin failures++; $display("FAIL sat_hit_cnt frame=%0d got=%0d want=%0d", i, bus.hit_cnt, exp_hit); end
    end
    checks++;
    if (bus.hit_cnt !== 8'hFF) begin failures++; $display("FAIL sat_final got=%h want=ff", bus.hit_cnt); end
  endtask
  task automatic test_random();
    do_reset();
    mask = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] w;
      logic stop, par;
      w = 4'($urandom);
      stop = $urandom_range(3) != 0;
      par = (^w) ^ ($urandom_range(4) == 0);
      send_frame(w, stop, par, $urandom_range(3));
      model(w, stop, par);
      checks += 3;
      if (bus.b !== exp_b) begin failures++; $display("FAIL rand_b got=%h want=%h", bus.b, exp_b); end
      if (nv !== int'(exp_good) || ne !== int'(!exp_good)) begin failures++; $display("FAIL rand_pulses valid=%0d err=%0d want valid=%0d", nv, ne, exp_good); end
      if (int'(bus.hit_cnt) !== exp_hit) begin failures++; $display("FAIL rand_hit got=%0d want=%0d", bus.hit_cnt, exp_hit); end
    end
  endtask
`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    send_frame(4'hB, 1'b1, 1'b0, 0);
    model(4'hB, 1'b1, 1'b0);
    checks += 2;
    if (ne !== 1 || nv !== 0) begin failures++; $display("FAIL par_bad err=%0d valid=%0d want err=1 valid=0", ne, nv); end
    send_frame(4'hB, 1'b1, 1'b1, 0);
    model(4'hB, 1'b1, 1'b1);
    if (bus.b !== 4'hB || nv !== 1 || ne !== 0) begin failures++; $display("FAIL par_good b=%h valid=%0d err=%0d want b=b valid=1 err=0", bus.b, nv, ne); end
  endtask
`endif
  initial begin
    bus.sen = 1'b0;
    bus.sdata = 1'b1;
    test_reset();
    test_basic();
    test_bad_stop();
    test_sweep();
    test_mid_reset();
    test_saturation();
    test_random();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
